// File: rtl/zebra_pkg.sv
// Shared types and helpers for the zebra-crossing stripe scanner.
package zebra_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FIRST = 2'd1,
    R_RUN   = 2'd2
  } run_state_e;

  typedef enum logic {
    CLS_BLACK = 1'b0,
    CLS_WHITE = 1'b1
  } pix_cls_e;

  localparam int MAX_RUN_DFLT = 160;

  // Run counter must hold MAX_RUN+1, the saturation value that marks "too long".
  function automatic int run_w(input int max_run);
    return $clog2(max_run + 2);
  endfunction

  localparam int RUN_W = run_w(MAX_RUN_DFLT);

  function automatic int unsigned popcount(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/zebra_stripe_run_counter.sv
// Run-length FSM for one scan row: measures stripe runs and tracks the longest
// chain of consecutive in-range runs. Time-shared across bands by the top.
module zebra_stripe_run_counter
  import zebra_pkg::*;
#(
  parameter int MIN_RUN  = 8,
  parameter int MAX_RUN  = 160,
  parameter int RUN_BITS = RUN_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       step,
  input  logic       first_px,
  input  logic       last_px,
  input  logic       cls,
  output logic [7:0] row_max,
  output logic [1:0] run_state
);

  localparam logic [1:0] ST_IDLE  = R_IDLE;
  localparam logic [1:0] ST_FIRST = R_FIRST;
  localparam logic [1:0] ST_RUN   = R_RUN;

  logic [1:0]          state_q, state_d;
  logic                prev_cls_q, prev_cls_d;
  logic [RUN_BITS-1:0] run_len_q, run_len_d;
  logic [7:0]          consec_q, consec_d;
  logic [7:0]          max_q, max_d;

  always_comb begin
    state_d    = state_q;
    prev_cls_d = prev_cls_q;
    run_len_d  = run_len_q;
    consec_d   = consec_q;
    max_d      = max_q;
    if (clr) begin
      state_d    = ST_IDLE;
      prev_cls_d = 1'b0;
      run_len_d  = '0;
      consec_d   = '0;
      max_d      = '0;
    end
    if (step) begin
      if (first_px) begin
        state_d    = ST_FIRST;
        prev_cls_d = cls;
        run_len_d  = RUN_BITS'(1);
        consec_d   = '0;
        max_d      = '0;
      end else begin
        case (state_q)
          // The run touching the left edge has no true start, so it is never scored.
          ST_FIRST: begin
            if (cls != prev_cls_q) begin
              state_d   = ST_RUN;
              run_len_d = RUN_BITS'(1);
            end
          end
          ST_RUN: begin
            if (cls != prev_cls_q) begin
              if (run_len_q >= RUN_BITS'(MIN_RUN) && run_len_q <= RUN_BITS'(MAX_RUN)) begin
                consec_d = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;
                if (consec_d > max_q) max_d = consec_d;
              end else begin
                consec_d = '0;
              end
              run_len_d = RUN_BITS'(1);
            end else if (run_len_q != RUN_BITS'(MAX_RUN + 1)) begin
              run_len_d = run_len_q + RUN_BITS'(1);
            end
          end
          default: ;
        endcase
        prev_cls_d = cls;
      end
      if (last_px) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prev_cls_q <= 1'b0;
      run_len_q  <= '0;
      consec_q   <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_cls_q <= prev_cls_d;
      run_len_q  <= run_len_d;
      consec_q   <= consec_d;
      max_q      <= max_d;
    end
  end

  assign row_max   = max_d;
  assign run_state = state_q;

endmodule

// File: rtl/zebra_stripe_scanner.sv
// Streaming zebra-crossing detector on a pixel passthrough; hysteretic
// pixel classification is enabled with the ZEBRA_HYST_EN macro.
module zebra_stripe_scanner
  import zebra_pkg::*;
#(
  parameter int IMG_WIDTH       = 640,
  parameter int IMG_HEIGHT      = 480,
  parameter int W               = 8,
  parameter int NUM_BANDS       = 4,
  parameter int BAND_ROW0       = 240,
  parameter int BAND_PITCH      = 32,
  parameter int MIN_RUN         = 8,
  parameter int MAX_RUN         = 160,
  parameter int MIN_STRIPES     = 6,
  parameter int MIN_BANDS_AGREE = 3,
  parameter int HYST            = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         white_thresh,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [W-1:0]         x_data,
  input  logic                 x_sof,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [W-1:0]         y_data,
  output logic                 crossing_detected,
  output logic                 detection_valid,
  output logic [NUM_BANDS-1:0] band_hits,
  output logic [7:0]           best_stripes,
  output logic [1:0]           dbg_run_state
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  if (BAND_ROW0 + (NUM_BANDS - 1) * BAND_PITCH >= IMG_HEIGHT) begin : g_bad_rows
    $error("zebra_stripe_scanner: last band row lies outside the image");
  end
  if (NUM_BANDS < 1 || NUM_BANDS > 8) begin : g_bad_bands
    $error("zebra_stripe_scanner: NUM_BANDS must be 1..8");
  end
  if (HYST < 0 || HYST >= (1 << W) || MIN_RUN > MAX_RUN) begin : g_bad_cfg
    $error("zebra_stripe_scanner: bad HYST or run limits");
  end

  // Valid/ready: a pixel transfers on a cycle where x_valid and y_ready are both
  // high; the scanner never stalls, so ready and valid are straight wires.
  assign x_ready = y_ready;
  assign y_valid = x_valid;
  assign y_data  = x_data;

  logic accept, abort, frame_end;
  logic [XW-1:0] x_q, x_d, px_x;
  logic [YW-1:0] y_q, y_d, px_y;
  logic first_px, last_px, last_row;

  assign accept = x_valid & y_ready;

  always_comb begin
    px_x     = x_sof ? '0 : x_q;
    px_y     = x_sof ? '0 : y_q;
    first_px = (px_x == '0);
    last_px  = (px_x == XW'(IMG_WIDTH - 1));
    last_row = (px_y == YW'(IMG_HEIGHT - 1));
    x_d      = x_q;
    y_d      = y_q;
    if (accept) begin
      if (last_px) begin
        x_d = '0;
        y_d = last_row ? '0 : px_y + YW'(1);
      end else begin
        x_d = px_x + XW'(1);
        y_d = px_y;
      end
    end
  end

  // A sof pixel is coordinate (0,0), so it can never also be the frame's last pixel.
  assign abort     = accept & x_sof & ((x_q != '0) | (y_q != '0));
  assign frame_end = accept & last_px & last_row;

  logic          band_row;
  logic [BW-1:0] band_idx;

  always_comb begin
    band_row = 1'b0;
    band_idx = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (px_y == YW'(BAND_ROW0 + k * BAND_PITCH)) begin
        band_row = 1'b1;
        band_idx = BW'(k);
      end
    end
  end

  logic pix_cls;

`ifdef ZEBRA_HYST_EN
  logic         cls_q;
  logic [W-1:0] hyst_low;
  logic         prev_cls;

  always_comb begin
    hyst_low = (white_thresh > W'(HYST)) ? white_thresh - W'(HYST) : '0;
    prev_cls = first_px ? CLS_BLACK : cls_q;
    if (x_data >= white_thresh)  pix_cls = CLS_WHITE;
    else if (x_data < hyst_low)  pix_cls = CLS_BLACK;
    else                         pix_cls = prev_cls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cls_q <= CLS_BLACK;
    else if (accept) cls_q <= pix_cls;
  end
`else
  assign pix_cls = (x_data >= white_thresh) ? CLS_WHITE : CLS_BLACK;
`endif

  logic [7:0] row_max;

  zebra_stripe_run_counter #(
    .MIN_RUN  (MIN_RUN),
    .MAX_RUN  (MAX_RUN),
    .RUN_BITS (run_w(MAX_RUN))
  ) u_run (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .step      (accept & band_row),
    .first_px  (first_px),
    .last_px   (last_px),
    .cls       (pix_cls),
    .row_max   (row_max),
    .run_state (dbg_run_state)
  );

  logic [NUM_BANDS-1:0] hits_acc_q, hits_acc_d;
  logic [7:0]           best_acc_q, best_acc_d;
  logic [NUM_BANDS-1:0] band_hits_q, band_hits_d;
  logic [7:0]           best_q, best_d;
  logic                 crossing_q, crossing_d;
  logic                 det_q, det_d;

  always_comb begin
    hits_acc_d  = hits_acc_q;
    best_acc_d  = best_acc_q;
    band_hits_d = band_hits_q;
    best_d      = best_q;
    crossing_d  = crossing_q;
    det_d       = 1'b0;
    if (accept & band_row & last_px) begin
      hits_acc_d[band_idx] = (row_max >= 8'(MIN_STRIPES));
      if (row_max > best_acc_d) best_acc_d = row_max;
    end
    if (frame_end) begin
      band_hits_d = hits_acc_d;
      best_d      = best_acc_d;
      crossing_d  = (popcount(8'(hits_acc_d)) >= MIN_BANDS_AGREE);
      det_d       = 1'b1;
      hits_acc_d  = '0;
      best_acc_d  = '0;
    end
    if (abort) begin
      hits_acc_d = '0;
      best_acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      hits_acc_q  <= '0;
      best_acc_q  <= '0;
      band_hits_q <= '0;
      best_q      <= '0;
      crossing_q  <= 1'b0;
      det_q       <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      hits_acc_q  <= hits_acc_d;
      best_acc_q  <= best_acc_d;
      band_hits_q <= band_hits_d;
      best_q      <= best_d;
      crossing_q  <= crossing_d;
      det_q       <= det_d;
    end
  end

  assign crossing_detected = crossing_q;
  assign detection_valid   = det_q;
  assign band_hits         = band_hits_q;
  assign best_stripes      = best_q;

endmodule

// File: tb/tb_zebra_stripe_scanner.sv
// Bench for zebra_stripe_scanner on a reduced 160x12 image with band rows 4/6/8/10;
// expected verdicts are hand-derived from the stripe patterns below.
module tb_zebra_stripe_scanner;

  localparam int IMG_WIDTH  = 160;
  localparam int IMG_HEIGHT = 12;
  localparam int NUM_BANDS  = 4;
  localparam int BAND_ROW0  = 4;
  localparam int BAND_PITCH = 2;
  localparam int FRAME_PIX  = IMG_WIDTH * IMG_HEIGHT;

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           white_thresh;
  logic                 x_valid;
  logic                 x_ready;
  logic [7:0]           x_data;
  logic                 x_sof;
  logic                 y_valid;
  logic                 y_ready;
  logic [7:0]           y_data;
  logic                 crossing_detected;
  logic                 detection_valid;
  logic [NUM_BANDS-1:0] band_hits;
  logic [7:0]           best_stripes;
  logic [1:0]           dbg_run_state;

  zebra_stripe_scanner #(
    .IMG_WIDTH       (IMG_WIDTH),
    .IMG_HEIGHT      (IMG_HEIGHT),
    .W               (8),
    .NUM_BANDS       (NUM_BANDS),
    .BAND_ROW0       (BAND_ROW0),
    .BAND_PITCH      (BAND_PITCH),
    .MIN_RUN         (8),
    .MAX_RUN         (40),
    .MIN_STRIPES     (6),
    .MIN_BANDS_AGREE (3),
    .HYST            (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .white_thresh      (white_thresh),
    .x_valid           (x_valid),
    .x_ready           (x_ready),
    .x_data            (x_data),
    .x_sof             (x_sof),
    .y_valid           (y_valid),
    .y_ready           (y_ready),
    .y_data            (y_data),
    .crossing_detected (crossing_detected),
    .detection_valid   (detection_valid),
    .band_hits         (band_hits),
    .best_stripes      (best_stripes),
    .dbg_run_state     (dbg_run_state)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [12:0] exp_q[$];
  logic [7:0]  pix_q[$];
  logic        gaps     = 1'b0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [12:0] mk(input logic c, input logic [3:0] h, input logic [7:0] b);
    return {c, h, b};
  endfunction

  // 1:P10 2:P4 3:P8 4:P7 5:P40 6:P41 7:mixed long-run row 8:170/185 toggling whites
  function automatic logic [7:0] pix_val(input int mode, input int x);
    int   period;
    logic white;
    period = 0;
    white  = 1'b0;
    case (mode)
      1: period = 10;
      2: period = 4;
      3: period = 8;
      4: period = 7;
      5: period = 40;
      6: period = 41;
      7: white = (x < 10) || (x >= 20 && x < 30) || (x >= 130 && x < 140) || (x >= 150);
      8: begin
        if (((x / 10) % 2) == 0) return (x % 2 == 0) ? 8'd185 : 8'd170;
        return 8'd0;
      end
      default: period = 0;
    endcase
    if (period != 0) white = ((x / period) % 2) == 0;
    return white ? 8'd128 : 8'd20;
  endfunction

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_px(input logic [7:0] d, input logic sof);
    int   tries;
    logic acc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        x_valid = 1'b0;
        x_sof   = 1'($urandom_range(0, 1));
        x_data  = 8'($urandom_range(0, 255));
        y_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
    x_valid = 1'b1;
    x_data  = d;
    x_sof   = sof;
    pix_q.push_back(d);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 64) begin
      y_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      acc = y_ready;
      #1;
      tries++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=stalled want=accepted");
    end
    x_valid = 1'b0;
    x_sof   = 1'b0;
  endtask

  // modes[4k+:4] selects the pattern for band k; filler covers all other rows.
  task automatic send_frame(input logic [15:0] modes, input int filler, input int npix,
                            input logic has_exp, input logic [12:0] exp_v);
    int x, y, mode;
    for (int i = 0; i < npix; i++) begin
      x    = i % IMG_WIDTH;
      y    = i / IMG_WIDTH;
      mode = filler;
      for (int k = 0; k < NUM_BANDS; k++)
        if (y == BAND_ROW0 + k * BAND_PITCH) mode = int'(modes[k*4 +: 4]);
      send_px(pix_val(mode, x), i == 0);
    end
    if (has_exp) exp_q.push_back(exp_v);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [7:0]  pe;
    logic [12:0] ve;
    checks++;
    if (y_valid !== x_valid || x_ready !== y_ready) begin
      failures++;
      $display("FAIL handshake_passthru got=v%b/r%b want=v%b/r%b", y_valid, x_ready, x_valid, y_ready);
    end
    if (y_valid && y_ready) begin
      checks++;
      if (pix_q.size() == 0) begin
        failures++;
        $display("FAIL y_data_extra got=%h want=none", y_data);
      end else begin
        pe = pix_q.pop_front();
        if (y_data !== pe) begin
          failures++;
          $display("FAIL y_data got=%h want=%h", y_data, pe);
        end
      end
    end
    if (detection_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_verdict got=%b_%b_%0d want=no_pulse",
                 crossing_detected, band_hits, best_stripes);
      end else begin
        ve = exp_q.pop_front();
        if ({crossing_detected, band_hits, best_stripes} !== ve) begin
          failures++;
          $display("FAIL verdict got=%b_%b_%0d want=%b_%b_%0d", crossing_detected, band_hits,
                   best_stripes, ve[12], ve[11:8], ve[7:0]);
        end
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      failures++;
      ve = exp_q.pop_front();
      $display("FAIL verdict_latency got=no_pulse want=%b_%b_%0d", ve[12], ve[11:8], ve[7:0]);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    x_valid      = 1'b0;
    x_data       = '0;
    x_sof        = 1'b0;
    y_ready      = 1'b1;
    white_thresh = 8'd128;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {crossing_detected, band_hits, best_stripes, detection_valid}, 14'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_frame(16'h0000, 0, FRAME_PIX, 1'b1, mk(1'b0, 4'h0, 8'd0));   // all black
    send_frame(16'h1111, 1, FRAME_PIX, 1'b1, mk(1'b1, 4'hF, 8'd14));  // all bands hit
    send_frame(16'h0011, 1, FRAME_PIX, 1'b1, mk(1'b0, 4'h3, 8'd14));  // two bands only
    send_frame(16'h2222, 2, FRAME_PIX, 1'b1, mk(1'b0, 4'h0, 8'd0));   // runs too short
    gaps = 1'b1;
    send_frame(16'h1111, 1, FRAME_PIX, 1'b1, mk(1'b1, 4'hF, 8'd14));  // stalls and bubbles
    gaps = 1'b0;
    send_frame(16'h4333, 1, FRAME_PIX, 1'b1, mk(1'b1, 4'h7, 8'd18));  // MIN_RUN edge, 3 agree
    send_frame(16'h0765, 1, FRAME_PIX, 1'b1, mk(1'b0, 4'h0, 8'd2));   // MAX_RUN edge, long run

    white_thresh = 8'd180;
`ifdef ZEBRA_HYST_EN
    send_frame(16'h8888, 0, FRAME_PIX, 1'b1, mk(1'b1, 4'hF, 8'd14));
`else
    send_frame(16'h8888, 0, FRAME_PIX, 1'b1, mk(1'b0, 4'h0, 8'd1));
`endif
    white_thresh = 8'd128;

    // sof in the middle of band row 6 aborts; only the following frame reports
    send_frame(16'h1111, 1, 6 * IMG_WIDTH + 80, 1'b0, '0);
    send_frame(16'h1100, 0, FRAME_PIX, 1'b1, mk(1'b0, 4'hC, 8'd14));

    // sof lands on what would have been the last pixel of the frame
    send_frame(16'h1111, 1, FRAME_PIX - 1, 1'b0, '0);
    send_frame(16'h0011, 1, FRAME_PIX, 1'b1, mk(1'b0, 4'h3, 8'd14));

    // asynchronous reset mid-frame
    send_frame(16'h1111, 1, 500, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset", {crossing_detected, band_hits, best_stripes, detection_valid}, 14'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(16'h1111, 1, FRAME_PIX, 1'b1, mk(1'b1, 4'hF, 8'd14));

    repeat (5) @(posedge clk);
    #1;
    chk("queues_drained", 14'(exp_q.size() + pix_q.size()), 14'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
